// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: boundary-scan register operating modes.
package jtag_pkg;

    localparam logic [1:0] MODE_FUNC   = 2'b00;
    localparam logic [1:0] MODE_SAMPLE = 2'b01;
    localparam logic [1:0] MODE_EXTEST = 2'b10;
    localparam logic [1:0] MODE_CLAMP  = 2'b11;

endpackage

// File: rtl/bsr_segment.sv
// One bypassable boundary-scan segment: SEG_W shift cells plus a 1-bit bypass flop.
module bsr_segment #(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             shift,
    input  logic             en,
    input  logic             sin,
    input  logic [SEG_W-1:0] p_in,
    output logic             sout,
    output logic [SEG_W-1:0] data
);

    logic byp;

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            byp  <= 1'b0;
        end else begin
            if (load) begin
                data <= p_in;
            end else if (shift && en) begin
                data <= {data[SEG_W-2:0], sin};
            end
            if (clear) begin
                byp <= 1'b0;
            end else if (shift && !en) begin
                byp <= sin;
            end
        end
    end

    assign sout = en ? data[SEG_W-1] : byp;

endmodule

// File: rtl/bsr_seg_chain.sv
// Segmented boundary-scan data register with SAMPLE/EXTEST/CLAMP modes,
// saturating shift counter and update-done pulse.
module bsr_seg_chain
    import jtag_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               SEGMENTS = 4,
    parameter int               CNT_W    = 8,
    parameter logic [WIDTH-1:0] UPD_RST  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tdi,
    output logic                tdo,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic [1:0]          mode,
    input  logic [SEGMENTS-1:0] seg_en,
    input  logic [WIDTH-1:0]    p_data_in,
    output logic [WIDTH-1:0]    p_data_out,
    output logic [CNT_W-1:0]    shift_count,
    output logic                update_pulse
);

    localparam int SEG_W = WIDTH / SEGMENTS;

    logic                clamp;
    logic                sft;
    logic                upd;
    logic [SEGMENTS-1:0] seg_en_q;
    logic                clamp_byp;
    logic [WIDTH-1:0]    upd_reg;
    logic [WIDTH-1:0]    sreg_all;
    logic [SEGMENTS:0]   link;

    assign clamp = (mode == MODE_CLAMP);
    assign sft   = shift_dr && !capture_dr;
    assign upd   = update_dr && !capture_dr && !shift_dr;

    assign link[0] = tdi;

    genvar k;
    for (k = 0; k < SEGMENTS; k++) begin : g_seg
        bsr_segment #(
            .SEG_W(SEG_W)
        ) u_seg (
            .clk  (clk),
            .rst  (rst),
            .load (capture_dr && !clamp && seg_en[k]),
            .clear(capture_dr),
            .shift(sft && !clamp),
            .en   (seg_en_q[k]),
            .sin  (link[k]),
            .p_in (p_data_in[k*SEG_W +: SEG_W]),
            .sout (link[k+1]),
            .data (sreg_all[k*SEG_W +: SEG_W])
        );
    end

    // Topology only changes on capture so a shift sequence sees a stable chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_en_q  <= '1;
            clamp_byp <= 1'b0;
        end else if (capture_dr) begin
            seg_en_q  <= seg_en;
            clamp_byp <= 1'b0;
        end else if (sft) begin
            clamp_byp <= tdi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_reg <= UPD_RST;
        end else if (upd && !clamp) begin
            for (int s = 0; s < SEGMENTS; s++) begin
                if (seg_en_q[s]) begin
                    upd_reg[s*SEG_W +: SEG_W] <= sreg_all[s*SEG_W +: SEG_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_count  <= '0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= upd;
            if (capture_dr) begin
                shift_count <= '0;
            end else if (sft && (shift_count != '1)) begin
                shift_count <= shift_count + CNT_W'(1);
            end
        end
    end

    assign tdo        = clamp ? clamp_byp : link[SEGMENTS];
    assign p_data_out = mode[1] ? upd_reg : p_data_in;

endmodule
